pdm_decimator: RTL and testbench

Second-order CIC (sinc²) decimator that converts a 1-bit pulse-density-modulated stream back into 12-bit unsigned PCM samples. It is the receive-side counterpart of the first-order delta-sigma DAC. It provides loopback self-test of the audio DAC path and digitises external 1-bit PDM sources, such as a comparator-based ADC or a PDM microphone.

---
 rtl/pdm_decimator.sv | 86 ++++++++
 tb/tb_pdm_decimator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// Second-order CIC decimator: 1-bit PDM in, 12-bit unsigned PCM out, one sample per 2**DEC_LOG2 strobes.
// Latency: output updates two edges after the cycle carrying the frame's last strobe; no back-pressure.
module pdm_decimator #(
    parameter int DEC_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pdm_en,
    input  logic        pdm_in,
    output logic [11:0] dout,
    output logic        dout_valid
);

    localparam int W     = 2 * DEC_LOG2 + 1;
    localparam int SHIFT = 2 * DEC_LOG2 - 12;
    localparam logic [DEC_LOG2-1:0] CNT_MAX = '1;
    localparam logic [DEC_LOG2-1:0] CNT_ONE = DEC_LOG2'(1);

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]        int1, int2;
    logic [W-1:0]        z1, z2;
    logic [W-1:0]        c1, c2, y;
    logic [DEC_LOG2-1:0] cnt;
    logic                tick;
    logic [11:0]         dout_d;

    // Comb differences are taken at the output rate; modular wrap cancels integrator overflow.
    assign c1     = int2 - z1;
    assign c2     = c1 - z2;
    assign y      = c2 >> SHIFT;
    assign dout_d = (|y[W-1:12]) ? 12'hFFF : y[11:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL0;
        end else begin
            state_q <= state_d;
        end
    end

    // The first two comb outputs see an unfilled delay line, so they are withheld.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                FILL0:   state_d = FILL1;
                FILL1:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int1       <= '0;
            int2       <= '0;
            cnt        <= '0;
            tick       <= 1'b0;
            z1         <= '0;
            z2         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (pdm_en) begin
                int1 <= int1 + {{(W-1){1'b0}}, pdm_in};
                int2 <= int2 + int1;
                cnt  <= cnt + CNT_ONE;
            end
            tick       <= pdm_en && (cnt == CNT_MAX);
            dout_valid <= tick && (state_q == RUN);
            if (tick) begin
                z1   <= int2;
                z2   <= c1;
                dout <= dout_d;
            end
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator at DEC_LOG2=6 and 7 side by side, checked against a triangular-FIR model.
module tb_pdm_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pdm_en = 1'b0;
    logic        pdm_in = 1'b0;
    logic [11:0] dout0, dout1;
    logic        vld0, vld1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdm_decimator #(.DEC_LOG2(6)) u_dut6 (
        .clk(clk), .rst(rst), .pdm_en(pdm_en), .pdm_in(pdm_in),
        .dout(dout0), .dout_valid(vld0)
    );

    pdm_decimator #(.DEC_LOG2(7)) u_dut7 (
        .clk(clk), .rst(rst), .pdm_en(pdm_en), .pdm_in(pdm_in),
        .dout(dout1), .dout_valid(vld1)
    );

    // sinc^2 is a triangular FIR over the last 2R accepted bits: weight k for k<R,
    // 2R-k above, where k=0 is the newest bit. Bits before reset count as zero.
    bit hist[$];
    int nstr;
    int frames  [2];
    bit pend    [2];
    int pend_val[2];
    bit pend_vld[2];
    int exp_dout[2];
    bit exp_vld [2];

    function automatic int lg(int u);
        return (u == 0) ? 6 : 7;
    endfunction

    function automatic int model_sample(int u);
        int r = 1 << lg(u);
        longint c2 = 0;
        longint yv;
        for (int k = 0; k < 2 * r; k++) begin
            int idx = hist.size() - 1 - k;
            if (idx >= 0 && hist[idx])
                c2 += (k < r) ? k : (2 * r - k);
        end
        yv = c2 >> (2 * lg(u) - 12);
        return (yv > 4095) ? 4095 : int'(yv);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            nstr = 0;
            for (int u = 0; u < 2; u++) begin
                frames[u] = 0; pend[u] = 0; exp_dout[u] = 0; exp_vld[u] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (pend[u]) begin
                    exp_dout[u] = pend_val[u];
                    exp_vld[u]  = pend_vld[u];
                    pend[u]     = 0;
                end else begin
                    exp_vld[u] = 0;
                end
            end
            if (pdm_en) begin
                hist.push_back(pdm_in);
                if (hist.size() > 256) void'(hist.pop_front());
                nstr++;
                for (int u = 0; u < 2; u++) begin
                    if (nstr % (1 << lg(u)) == 0) begin
                        frames[u]++;
                        pend[u]     = 1;
                        pend_val[u] = model_sample(u);
                        pend_vld[u] = (frames[u] >= 3);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("dout_L6", dout0, exp_dout[0]);
        chk("valid_L6", vld0, exp_vld[0]);
        chk("dout_L7", dout1, exp_dout[1]);
        chk("valid_L7", vld1, exp_vld[1]);
    end

    int dac_acc = 0;
    int dens = 50;

    // mode 0: hold inputs, 1: delta-sigma DAC source, 2: strobe toggling with ones, 3: random
    task automatic cyc(input int mode, input int din);
        @(negedge clk);
        #1;
        case (mode)
            1: begin
                int s = dac_acc + din;
                pdm_en  = 1'b1;
                pdm_in  = (s >= 4096);
                dac_acc = s % 4096;
            end
            2: begin
                pdm_en = ~pdm_en;
                pdm_in = 1'b1;
            end
            3: begin
                if (rst) begin
                    rst = 1'b0;
                end else if ($urandom_range(0, 2999) == 0) begin
                    rst = 1'b1;
                    #1;
                    chk("async_clear_dout", dout0 | dout1, 0);
                    chk("async_clear_valid", vld0 | vld1, 0);
                end
                pdm_en = ($urandom_range(0, 3) != 0);
                pdm_in = ($urandom_range(0, 99) < dens);
            end
            default: ;
        endcase
    endtask

    task automatic first_valid(input int bound, output int t0, output int t1);
        t0 = -1;
        t1 = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (vld0 && t0 < 0) t0 = c;
            if (vld1 && t1 < 0) t1 = c;
            if (t0 >= 0 && t1 >= 0) break;
        end
    endtask

    initial begin
        int t0, t1;
        int g0a, g0b, g1a, g1b;
        int dins[4] = '{1024, 2048, 3072, 512};

        // reset, then idle with no strobes
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        chk("reset_dout", dout0 | dout1, 0);
        chk("reset_valid", vld0 | vld1, 0);
        repeat (50) cyc(0, 0);
        chk("idle_dout", dout0 | dout1, 0);

        // full scale from a clean frame boundary
        pdm_en = 1'b1;
        pdm_in = 1'b1;
        first_valid(1000, t0, t1);
        chk("first_valid_cycle_L6", t0, 193);
        chk("first_valid_cycle_L7", t1, 385);
        chk("full_scale_L6", dout0, 4095);
        chk("full_scale_L7", dout1, 4095);
        repeat (600) cyc(0, 0);
        chk("full_scale_hold_L6", dout0, 4095);

        pdm_in = 1'b0;
        repeat (1000) cyc(0, 0);
        chk("zero_L6", dout0, 0);
        chk("zero_L7", dout1, 0);

        foreach (dins[i]) begin
            repeat (1000) cyc(1, dins[i]);
            chk("dac_L6", dout0, dins[i]);
            chk("dac_L7", dout1, dins[i]);
        end

        // strobe gating: outputs every 2R clocks
        repeat (1000) cyc(2, 0);
        g0a = -1; g0b = -1; g1a = -1; g1b = -1;
        for (int c = 1; c <= 700; c++) begin
            cyc(2, 0);
            if (vld0) begin
                if (g0a < 0) g0a = c; else if (g0b < 0) g0b = c;
            end
            if (vld1) begin
                if (g1a < 0) g1a = c; else if (g1b < 0) g1b = c;
            end
        end
        chk("gated_period_L6", g0b - g0a, 128);
        chk("gated_period_L7", g1b - g1a, 256);
        chk("gated_value_L6", dout0, 4095);

        // mid-frame reset during a full-scale stream
        pdm_en = 1'b1;
        pdm_in = 1'b1;
        repeat (100) cyc(0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midframe_clear_dout", dout0 | dout1, 0);
        chk("midframe_clear_valid", vld0 | vld1, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        first_valid(1000, t0, t1);
        chk("post_reset_valid_L6", t0, 193);
        chk("post_reset_valid_L7", t1, 385);
        chk("post_reset_value_L6", dout0, 4095);
        chk("post_reset_value_L7", dout1, 4095);

        for (int blk = 0; blk < 10; blk++) begin
            dens = $urandom_range(0, 100);
            repeat (2000) cyc(3, 0);
        end
        rst = 1'b0;
        repeat (5) cyc(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
